// File: rtl/i2c_pkg.sv
// Shared definitions for the oversampling I2C target: FSM encoding, counter width,
// general-call address and the debug snapshot struct.
package i2c_pkg;

  localparam int BIT_CNT_W = 3;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_WR_BYTE  = 3'd3;
  localparam logic [2:0] ST_WR_ACK   = 3'd4;
  localparam logic [2:0] ST_RD_BYTE  = 3'd5;
  localparam logic [2:0] ST_RD_ACK   = 3'd6;
  localparam logic [2:0] ST_IGNORE   = 3'd7;

  localparam logic [6:0] GENERAL_CALL_ADDR = 7'h00;

  typedef struct packed {
    logic [2:0]           state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 busy;
  } i2c_dbg_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for one asynchronous I2C line with single-cycle rise/fall strobes.
module i2c_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Reset to the idle bus level so releasing reset never fakes an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/i2c_receptor_param.sv
// I2C target oversampling SCL/SDA on clk_receptor; moves DATA_BYTES-wide words.
// Build macro I2C_GENERAL_CALL_EN additionally accepts writes to the general-call address.
module i2c_receptor_param
  import i2c_pkg::*;
#(
  parameter int DATA_BYTES  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_receptor,
  input  logic                    rst_receptor,
  input  logic [6:0]              I2C_ADDR_receptor,
  input  logic                    SCL,
  input  logic                    SDA_OUT,
  input  logic                    SDA_OE,
  input  logic [8*DATA_BYTES-1:0] RD_DATA_receptor,
  output logic                    SDA_IN,
  output logic [8*DATA_BYTES-1:0] WR_DATA_receptor,
  output logic                    wr_valid,
  output logic                    rd_req,
  output logic                    busy,
  output i2c_dbg_t                dbg_o
);

  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int BC_W   = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  logic bus_sda;
  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  assign bus_sda = SDA_OE ? SDA_OUT : 1'b1;

  i2c_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_scl (
    .clk_i   (clk_receptor),
    .rst_ni  (rst_receptor),
    .d_i     (SCL),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sda (
    .clk_i   (clk_receptor),
    .rst_ni  (rst_receptor),
    .d_i     (bus_sda),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  // Both lines share the same latency, so SCL level is aligned with the SDA edge.
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  logic [2:0]           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BC_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic                 byte_done_q, byte_done_d;
  logic [7:0]           shift_q, shift_d;
  logic                 rnw_q, rnw_d;
  logic [DATA_W-1:0]    word_q, word_d, word_next;
  logic [DATA_W-1:0]    rd_shift_q, rd_shift_d;
  logic                 sda_in_q, sda_in_d;
  logic                 busy_q, busy_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 rd_req_q, rd_req_d;
  logic                 addr_match;
  logic                 last_byte;

  if (DATA_BYTES > 1) begin : g_multi
    assign word_next = {word_q[DATA_W-9:0], shift_q};
  end else begin : g_single
    assign word_next = shift_q;
  end

  assign last_byte = (byte_cnt_q == BC_W'(DATA_BYTES - 1));

  always_comb begin
`ifdef I2C_GENERAL_CALL_EN
    if (shift_q[7:1] == GENERAL_CALL_ADDR) addr_match = ~shift_q[0];
    else                                   addr_match = (shift_q[7:1] == I2C_ADDR_receptor);
`else
    addr_match = (shift_q[7:1] == I2C_ADDR_receptor);
`endif
  end

  // Bits are taken on SCL rise; SDA_IN and state advance on SCL fall.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    byte_done_d = byte_done_q;
    shift_d     = shift_q;
    rnw_d       = rnw_q;
    word_d      = word_q;
    rd_shift_d  = rd_shift_q;
    sda_in_d    = sda_in_q;
    busy_d      = busy_q;
    wr_data_d   = wr_data_q;
    wr_valid_d  = 1'b0;
    rd_req_d    = 1'b0;
    if (start_det) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = '0;
      byte_cnt_d  = '0;
      byte_done_d = 1'b0;
      sda_in_d    = 1'b1;
    end else if (stop_det) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      byte_cnt_d  = '0;
      byte_done_d = 1'b0;
      sda_in_d    = 1'b1;
      busy_d      = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ST_ADDR, ST_WR_BYTE, ST_RD_BYTE: begin
          shift_d   = {shift_q[6:0], sda_lvl};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
        end
        ST_RD_ACK: begin
          if (sda_lvl) begin
            state_d  = ST_IGNORE;
            sda_in_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR: begin
          if (byte_done_q) begin
            byte_done_d = 1'b0;
            if (addr_match) begin
              state_d  = ST_ADDR_ACK;
              sda_in_d = 1'b0;
              busy_d   = 1'b1;
              rnw_d    = shift_q[0];
            end else begin
              state_d  = ST_IGNORE;
              sda_in_d = 1'b1;
            end
          end
        end
        ST_ADDR_ACK: begin
          byte_cnt_d = '0;
          if (rnw_q) begin
            state_d    = ST_RD_BYTE;
            rd_req_d   = 1'b1;
            sda_in_d   = RD_DATA_receptor[DATA_W-1];
            rd_shift_d = RD_DATA_receptor << 1;
          end else begin
            state_d  = ST_WR_BYTE;
            sda_in_d = 1'b1;
          end
        end
        ST_WR_BYTE: begin
          if (byte_done_q) begin
            byte_done_d = 1'b0;
            state_d     = ST_WR_ACK;
            sda_in_d    = 1'b0;
            word_d      = word_next;
          end
        end
        ST_WR_ACK: begin
          state_d  = ST_WR_BYTE;
          sda_in_d = 1'b1;
          if (last_byte) begin
            byte_cnt_d = '0;
            wr_data_d  = word_q;
            wr_valid_d = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
        ST_RD_BYTE: begin
          if (byte_done_q) begin
            byte_done_d = 1'b0;
            state_d     = ST_RD_ACK;
            sda_in_d    = 1'b1;
          end else begin
            sda_in_d   = rd_shift_q[DATA_W-1];
            rd_shift_d = rd_shift_q << 1;
          end
        end
        ST_RD_ACK: begin
          // Reaching this fall still in RD_ACK means the master ACKed.
          state_d = ST_RD_BYTE;
          if (last_byte) begin
            byte_cnt_d = '0;
            rd_req_d   = 1'b1;
            sda_in_d   = RD_DATA_receptor[DATA_W-1];
            rd_shift_d = RD_DATA_receptor << 1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            sda_in_d   = rd_shift_q[DATA_W-1];
            rd_shift_d = rd_shift_q << 1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_receptor or negedge rst_receptor) begin
    if (!rst_receptor) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      byte_done_q <= 1'b0;
      shift_q     <= '0;
      rnw_q       <= 1'b0;
      word_q      <= '0;
      rd_shift_q  <= '0;
      sda_in_q    <= 1'b1;
      busy_q      <= 1'b0;
      wr_data_q   <= '0;
      wr_valid_q  <= 1'b0;
      rd_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      byte_done_q <= byte_done_d;
      shift_q     <= shift_d;
      rnw_q       <= rnw_d;
      word_q      <= word_d;
      rd_shift_q  <= rd_shift_d;
      sda_in_q    <= sda_in_d;
      busy_q      <= busy_d;
      wr_data_q   <= wr_data_d;
      wr_valid_q  <= wr_valid_d;
      rd_req_q    <= rd_req_d;
    end
  end

  // wr_valid and rd_req are single-cycle strobes with no back-pressure.
  assign SDA_IN           = sda_in_q;
  assign WR_DATA_receptor = wr_data_q;
  assign wr_valid         = wr_valid_q;
  assign rd_req           = rd_req_q;
  assign busy             = busy_q;
  assign dbg_o            = '{state: state_q, bit_cnt: bit_cnt_q, busy: busy_q};

endmodule

// File: tb/tb_i2c_receptor_param.sv
// Bench for i2c_receptor_param: table of bus transactions plus reset-mid-read sequence.
module tb_i2c_receptor_param;
  import i2c_pkg::*;

  localparam int DB = 2;
  localparam int DW = 8 * DB;
  localparam int Q  = 40;

  logic          clk_receptor;
  logic          rst_receptor;
  logic [6:0]    I2C_ADDR_receptor;
  logic          SCL;
  logic          SDA_OUT;
  logic          SDA_OE;
  logic [DW-1:0] RD_DATA_receptor;
  logic          SDA_IN;
  logic [DW-1:0] WR_DATA_receptor;
  logic          wr_valid;
  logic          rd_req;
  logic          busy;
  i2c_dbg_t      dbg;

  i2c_receptor_param #(.DATA_BYTES(DB), .SYNC_STAGES(2)) dut (
    .clk_receptor      (clk_receptor),
    .rst_receptor      (rst_receptor),
    .I2C_ADDR_receptor (I2C_ADDR_receptor),
    .SCL               (SCL),
    .SDA_OUT           (SDA_OUT),
    .SDA_OE            (SDA_OE),
    .RD_DATA_receptor  (RD_DATA_receptor),
    .SDA_IN            (SDA_IN),
    .WR_DATA_receptor  (WR_DATA_receptor),
    .wr_valid          (wr_valid),
    .rd_req            (rd_req),
    .busy              (busy),
    .dbg_o             (dbg)
  );

  // Clock and watchdog
  initial begin
    clk_receptor = 1'b0;
    forever #5 clk_receptor = ~clk_receptor;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  int rd_req_cnt = 0;
  int exp_rd_req = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_last = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: each wr_valid pops one expected word
  always @(negedge clk_receptor) begin
    if (rd_req) rd_req_cnt++;
    if (wr_valid) begin
      check("wr_valid_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("wr_word", WR_DATA_receptor, exp_q.pop_front());
    end
  end

  // Bus driver tasks
  task automatic i2c_start();
    SDA_OE = 1'b1; SDA_OUT = 1'b1; #Q;
    SCL = 1'b1; #Q;
    SDA_OUT = 1'b0; #Q;
    SCL = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    SDA_OE = 1'b1; SDA_OUT = 1'b0; #Q;
    SCL = 1'b1; #Q;
    SDA_OUT = 1'b1; #Q;
  endtask

  task automatic write_bit(input logic b);
    SDA_OE = 1'b1; SDA_OUT = b; #Q;
    SCL = 1'b1; #(2*Q);
    SCL = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    SDA_OE = 1'b0; #Q;
    SCL = 1'b1; #Q;
    b = SDA_IN; #Q;
    SCL = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
  endtask

  task automatic recv_byte(output logic [7:0] v);
    logic bv;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bv);
      v[i] = bv;
    end
  endtask

  typedef struct {
    logic [6:0]    addr;
    logic          rnw;
    int            nbytes;
    logic [31:0]   data;
    logic [DW-1:0] rd_data;
    logic          exp_ack;
    logic          end_rs;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    logic          ack;
    logic [7:0]    rb;
    logic [7:0]    b;
    logic [DW-1:0] word;
    word = '0;
    RD_DATA_receptor = v.rd_data;
    i2c_start();
    send_byte({v.addr, v.rnw});
    read_bit(ack);
    check("addr_ack", ack, v.exp_ack ? 1'b0 : 1'b1);
    check("busy_after_addr", busy, v.exp_ack);
    if (!v.exp_ack) check("state_ignore", dbg.state, ST_IGNORE);
    if (v.exp_ack && !v.rnw) begin
      for (int i = 0; i < v.nbytes; i++) begin
        b = v.data[31-8*i -: 8];
        send_byte(b);
        word = {word[7:0], b};
        if (i % 2 == 1) begin
          exp_q.push_back(word);
          exp_last = word;
        end
        read_bit(ack);
        check("data_ack", ack, 0);
      end
    end else if (v.exp_ack) begin
      exp_rd_req += 1 + (v.nbytes - 1) / 2;
      for (int i = 0; i < v.nbytes; i++) begin
        recv_byte(rb);
        check("rd_byte", rb, (i % 2 == 0) ? v.rd_data[15:8] : v.rd_data[7:0]);
        write_bit(i == v.nbytes - 1);
      end
      check("sda_released_after_nack", SDA_IN, 1);
    end
    if (!v.end_rs) begin
      i2c_stop();
      #(4*Q);
      check("busy_after_stop", busy, 0);
      check("sda_idle_after_stop", SDA_IN, 1);
    end
    check("rd_req_count", rd_req_cnt, exp_rd_req);
    check("wr_data_hold", WR_DATA_receptor, exp_last);
  endtask

  initial begin
    logic       bv;
    logic [3:0] nib;
    rst_receptor      = 1'b0;
    SCL               = 1'b1;
    SDA_OUT           = 1'b1;
    SDA_OE            = 1'b0;
    I2C_ADDR_receptor = 7'h3D;
    RD_DATA_receptor  = '0;

    vecs[0] = '{7'h3D, 1'b0, 2, 32'hBEEF_0000, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{7'h3D, 1'b1, 2, 32'h0,         16'hA55A, 1'b1, 1'b0};
    vecs[2] = '{7'h20, 1'b0, 0, 32'h0,         16'h0000, 1'b0, 1'b0};
    vecs[3] = '{7'h3D, 1'b0, 3, 32'h1234_5600, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{7'h3D, 1'b0, 2, 32'hABCD_0000, 16'h0000, 1'b1, 1'b0};
`ifdef I2C_GENERAL_CALL_EN
    vecs[5] = '{7'h00, 1'b0, 2, 32'hCAFE_0000, 16'h0000, 1'b1, 1'b0};
`else
    vecs[5] = '{7'h00, 1'b0, 2, 32'hCAFE_0000, 16'h0000, 1'b0, 1'b0};
`endif
    vecs[6] = '{7'h3D, 1'b1, 4, 32'h0,         16'h1234, 1'b1, 1'b0};
    vecs[7] = '{7'h3D, 1'b0, 4, $urandom(),    16'h0000, 1'b1, 1'b0};
    vecs[7].rd_data = 16'($urandom_range(0, 65535));

    #(2*Q);
    check("rst_sda_in", SDA_IN, 1);
    check("rst_wr_data", WR_DATA_receptor, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg.state, ST_IDLE);
    rst_receptor = 1'b1;
    #(4*Q);

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Reset asserted while bit 4 of a read byte is on the wire
    RD_DATA_receptor = 16'hA55A;
    i2c_start();
    send_byte({7'h3D, 1'b1});
    read_bit(bv);
    check("mid_read_addr_ack", bv, 0);
    exp_rd_req++;
    for (int i = 3; i >= 0; i--) begin
      read_bit(bv);
      nib[i] = bv;
    end
    check("mid_read_nibble", nib, 4'hA);
    #(Q/2);
    check("mid_read_bit4_driven", SDA_IN, 0);
    rst_receptor = 1'b0;
    #1;
    check("async_rst_sda_in", SDA_IN, 1);
    check("async_rst_state", dbg.state, ST_IDLE);
    check("async_rst_busy", busy, 0);
    check("async_rst_wr_data", WR_DATA_receptor, 0);
    exp_last = '0;
    #(Q-1);
    rst_receptor = 1'b1;
    SCL = 1'b1;
    #(2*Q);
    run_vec(vecs[0]);

    #(2*Q);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_receptor_param.md
Name: i2c_receptor_param

Overview:
- Parametrised next-generation I2C target (receiver) block.
- Oversamples SCL and SDA on the system clock instead of clocking logic on SCL.
- Detects START, repeated START and STOP; matches a programmable 7-bit address; services multi-word reads and writes of DATA_BYTES bytes per word.
- Sits between the I2C transaction generator (or a bench emulating it) and CPU-side registers.

Parameters:
- DATA_BYTES, 2: bytes per parallel word; DATA_W = 8*DATA_BYTES.
- SYNC_STAGES, 2: synchroniser flops on SCL and SDA_OUT/SDA_OE (minimum 2).

Ports:
- clk_receptor  in  1  system clock; must be at least 8x the SCL frequency.
- rst_receptor  in  1  asynchronous, active-low reset.
- I2C_ADDR_receptor  in  7  own target address, sampled at each address phase.
- SCL  in  1  I2C clock from the generator.
- SDA_OUT  in  1  serial data from the generator.
- SDA_OE  in  1  generator drive enable; bus SDA = SDA_OE ? SDA_OUT : 1.
- RD_DATA_receptor  in  DATA_W  word to transmit on reads; MSB first.
- SDA_IN  out  1  serial data/ACK to the generator; 1 means released.
- WR_DATA_receptor  out  DATA_W  last complete written word.
- wr_valid  out  1  one-cycle pulse when WR_DATA_receptor updates.
- rd_req  out  1  one-cycle pulse when RD_DATA_receptor is captured.
- busy  out  1  high from an address-matched START until STOP.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): state=IDLE, SDA_IN=1, WR_DATA_receptor=0, wr_valid=0, rd_req=0, busy=0; bit and byte counters cleared.
- Edge detection: SCL and bus SDA pass through SYNC_STAGES flops plus one edge-detect flop.
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
  - Bits are sampled on the SCL rise. SDA_IN changes only on the SCL fall, one clk_receptor cycle after the fall is detected.
- START or repeated START in any state: go to ADDR, clear the bit counter, release SDA_IN. STOP in any state: go to IDLE, SDA_IN=1, busy=0.
- States:
  - IDLE.
  - ADDR: 8 bits, MSB first; 7 address bits then RNW.
  - ADDR_ACK.
  - WR_BYTE, WR_ACK.
  - RD_BYTE, RD_ACK.
  - IGNORE: wait for START/STOP.
- ADDR: after the 8th bit, if address == I2C_ADDR_receptor, drive SDA_IN=0 for the ACK clock and set busy. Otherwise go to IGNORE with SDA_IN=1 (NACK).
- Write path (RNW=0):
  - WR_BYTE shifts 8 bits; WR_ACK drives SDA_IN=0 for one SCL period.
  - After byte DATA_BYTES-1 is ACKed, WR_DATA_receptor takes the assembled word and wr_valid pulses on the SCL fall ending the ACK.
  - The byte counter wraps to 0, so further bytes form the next word.
  - A partial word at STOP or repeated START is discarded: no wr_valid, WR_DATA_receptor unchanged.
- Read path (RNW=1):
  - RD_DATA_receptor is captured into a shift register, with an rd_req pulse, on the SCL fall ending the address ACK.
  - RD_BYTE drives bits MSB first, changing on each SCL fall.
  - RD_ACK releases SDA_IN and samples the master bit on the SCL rise.
  - Master ACK (0): continue with the next byte. After byte DATA_BYTES-1, recapture RD_DATA_receptor and pulse rd_req.
  - Master NACK (1): release SDA_IN, go to IGNORE.
- The block never drives SDA_IN=0 outside ADDR_ACK, WR_ACK or a 0 data bit in RD_BYTE.
- SDA changing while SCL is high inside a byte is a START/STOP, never a data bit.

Optional Feature:
- Macro I2C_GENERAL_CALL_EN.
- Defined: address 7'h00 with RNW=0 also matches; the block ACKs and accepts write words as normal. Address 7'h00 with RNW=1 is NACKed.
- Undefined: 7'h00 matches only if I2C_ADDR_receptor==7'h00.

Decomposition:
- Package i2c_pkg holds:
  - the state encoding: IDLE=0, ADDR=1, ADDR_ACK=2, WR_BYTE=3, WR_ACK=4, RD_BYTE=5, RD_ACK=6, IGNORE=7;
  - GENERAL_CALL_ADDR=7'h00;
  - bit-counter width 3.
- Sub-module i2c_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs. Instantiated for SCL and for bus SDA.

Test Plan:
- Write, I2C_ADDR_receptor=7'h3D, DATA_BYTES=2: START, 0x7A, bytes 0xBE 0xEF, STOP -> three ACKs (SDA_IN=0) at the ACK clocks; one wr_valid; WR_DATA_receptor=16'hBEEF.
- Read, RD_DATA_receptor=16'hA55A: START, 0x7B, master ACK then NACK -> rd_req once; SDA_IN serialises 1010_0101_0101_1010; SDA_IN=1 after NACK; busy falls at STOP.
- Address mismatch, START 0x20 -> SDA_IN stays 1 through the ACK clock; no wr_valid or rd_req; busy=0.
- Partial and multi-word: write 3 bytes 0x12 0x34 0x56 then repeated START -> single wr_valid with 16'h1234; 0x56 discarded; new address phase is ACKed.
- Reset mid-read: assert rst_receptor low during RD_BYTE bit 4 -> SDA_IN=1 and state IDLE immediately, asynchronously; next START is handled normally.
- I2C_GENERAL_CALL_EN: write to 0x00 with data 0xCAFE -> ACKed, WR_DATA_receptor=16'hCAFE when defined; NACKed and unchanged when undefined.
